// File: rtl/fp_pkg.sv
// Shared single-precision constants, operand classification and the divider/multiplier state enum.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;
    localparam int WORD_W = EXP_W + MAN_W + 1;
    localparam int SIG_W  = MAN_W + 1;
    localparam int ITER   = MAN_W + 2;
    localparam int REM_W  = MAN_W + 3;

    localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;
    localparam logic [WORD_W-1:0] INF  = 32'h7F80_0000;

    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIV_ZERO  = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        RND,
        DONE
    } state_t;

    typedef struct packed {
        logic sign;
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    // Denormals (exponent field 0) classify as zero so they flush before any check.
    function automatic fp_class_t classify(input logic [WORD_W-1:0] x);
        fp_class_t r;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e      = x[WORD_W-2:MAN_W];
        f      = x[MAN_W-1:0];
        r.sign = x[WORD_W-1];
        r.zero = (e == '0);
        r.inf  = (e == '1) && (f == '0);
        r.nan  = (e == '1) && (f != '0);
        return r;
    endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// Radix-2 restoring mantissa divider: one quotient bit per clock, ITER bits per operation.
module fp_div_mant_core
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [SIG_W-1:0]  ma,
    input  logic [SIG_W-1:0]  mb,
    output logic              last,
    output logic [ITER-1:0]   q,
    output logic [REM_W-1:0]  rem
);

    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] done_cnt;
    logic [SIG_W-1:0] mb_r;
    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] rem_nxt;
    logic [REM_W-1:0] mb_ext;
    logic             q_bit;

    // The first step compares the loaded dividend directly; later steps shift first.
    always_comb begin
        mb_ext  = {{(REM_W-SIG_W){1'b0}}, mb_r};
        rem_sh  = (done_cnt == CNT_INIT) ? rem : {rem[REM_W-2:0], 1'b0};
        q_bit   = (rem_sh >= mb_ext);
        rem_nxt = q_bit ? (rem_sh - mb_ext) : rem_sh;
    end

    assign last = (done_cnt == CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt <= '0;
            mb_r     <= '0;
            rem      <= '0;
            q        <= '0;
        end else if (load) begin
            done_cnt <= CNT_INIT;
            mb_r     <= mb;
            rem      <= shift ? {1'b0, ma, 1'b0} : {2'b00, ma};
            q        <= '0;
        end else if (done_cnt != '0) begin
            done_cnt <= done_cnt - CNT_ONE;
            rem      <= rem_nxt;
            q        <= {q[ITER-2:0], q_bit};
        end
    end

endmodule

// File: rtl/fp_div_iter.sv
// Multi-cycle single-precision divider c = a / b with RNE rounding and flush-to-zero.
//   state | meaning
//   IDLE  | ready for operands; specials resolve straight to DONE
//   DIV   | mantissa core producing one quotient bit per cycle
//   RND   | round-to-nearest-even and exponent range check
//   DONE  | result held until out_ready
module fp_div_iter
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] c,
    output logic [4:0]        flags
);

    localparam int E_W = EXP_W + 2;
    localparam logic signed [E_W-1:0] E_MAX  = E_W'(2**EXP_W - 1);
    localparam logic signed [E_W-1:0] E_ZERO = '0;

    state_t state;
    state_t state_nxt;

    fp_class_t          ca;
    fp_class_t          cb;
    logic               sign_ab;
    logic               special;
    logic [WORD_W-1:0]  spec_c;
    logic [4:0]         spec_flags;
    logic               accept;
    logic               load;
    logic [SIG_W-1:0]   ma;
    logic [SIG_W-1:0]   mb;
    logic               norm_shift;
    logic               core_last;
    logic [ITER-1:0]    q;
    logic [REM_W-1:0]   rem;

    logic signed [E_W-1:0] e_load;
    logic signed [E_W-1:0] e_r;
    logic signed [E_W-1:0] e_rnd;
    logic                  s_r;

    logic               guard;
    logic               sticky;
    logic               inc;
    logic               carry;
    logic [SIG_W:0]     sig_rnd;
    logic [MAN_W-1:0]   frac_rnd;
    logic [WORD_W-1:0]  rnd_c;
    logic [4:0]         rnd_flags;

    assign ca      = classify(a);
    assign cb      = classify(b);
    assign sign_ab = ca.sign ^ cb.sign;
    assign accept  = in_valid & in_ready;
    assign load    = accept & ~special;

    always_comb begin
        special    = 1'b1;
        spec_c     = '0;
        spec_flags = '0;
        if (ca.nan || cb.nan || (ca.zero && cb.zero) || (ca.inf && cb.inf)) begin
            spec_c                   = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (ca.inf || cb.zero) begin
            spec_c                    = {sign_ab, INF[WORD_W-2:0]};
            spec_flags[FLAG_DIV_ZERO] = cb.zero & ~ca.inf;
        end else if (ca.zero || cb.inf) begin
            spec_c = {sign_ab, {(WORD_W-1){1'b0}}};
        end else begin
            special = 1'b0;
        end
    end

    // Pre-normalise so the quotient lands in [1,2); the exponent absorbs the shift.
    assign ma         = {1'b1, a[MAN_W-1:0]};
    assign mb         = {1'b1, b[MAN_W-1:0]};
    assign norm_shift = (ma < mb);
    assign e_load     = signed'({2'b00, a[WORD_W-2:MAN_W]})
                      - signed'({2'b00, b[WORD_W-2:MAN_W]})
                      + E_W'(BIAS) - E_W'(norm_shift);

    fp_div_mant_core u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (norm_shift),
        .ma    (ma),
        .mb    (mb),
        .last  (core_last),
        .q     (q),
        .rem   (rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : DIV;
            DIV:  if (core_last) state_nxt = RND;
            RND:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // q holds 24 significand bits above one guard bit; the remainder supplies sticky.
    always_comb begin
        guard    = q[0];
        sticky   = |rem;
        inc      = guard & (sticky | q[1]);
        sig_rnd  = {1'b0, q[ITER-1:1]} + {{SIG_W{1'b0}}, inc};
        carry    = sig_rnd[SIG_W];
        frac_rnd = carry ? sig_rnd[SIG_W-1:1] : sig_rnd[MAN_W-1:0];
        e_rnd    = e_r + E_W'(carry);

        rnd_c                   = {s_r, e_rnd[EXP_W-1:0], frac_rnd};
        rnd_flags               = '0;
        rnd_flags[FLAG_INEXACT] = guard | sticky;
        if (e_rnd >= E_MAX) begin
            rnd_c                     = {s_r, INF[WORD_W-2:0]};
            rnd_flags[FLAG_OVERFLOW]  = 1'b1;
            rnd_flags[FLAG_INEXACT]   = 1'b1;
        end else if (e_rnd <= E_ZERO) begin
            rnd_c                     = {s_r, {(WORD_W-1){1'b0}}};
            rnd_flags[FLAG_UNDERFLOW] = 1'b1;
            rnd_flags[FLAG_INEXACT]   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c     <= '0;
            flags <= '0;
            s_r   <= 1'b0;
            e_r   <= '0;
        end else if (accept) begin
            s_r   <= sign_ab;
            e_r   <= e_load;
            flags <= special ? spec_flags : 5'd0;
            if (special) begin
                c <= spec_c;
            end
        end else if (state == RND) begin
            c     <= rnd_c;
            flags <= rnd_flags;
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: literal vectors plus a per-cycle compare against an arithmetic model.
module tb_fp_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] c;
    logic [4:0]  flags;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    typedef struct packed {
        logic [31:0] c;
        logic [4:0]  f;
        logic        special;
    } res_t;

    typedef struct {
        logic [31:0] c;
        logic [4:0]  f;
        int          acc;
        int          lat;
    } pend_t;

    pend_t pend[$];
    pend_t item;
    res_t  mres;

    fp_div_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Exact quotient by integer division, then round-to-nearest-even on the 24-bit significand.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
        res_t        r;
        int          ex, ey, e;
        logic [63:0] mx, my, num, qq, rr, sig;
        logic        s, g, st, zx, zy, ix, iy, nx, ny;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = {40'd0, 1'b1, x[22:0]};
        my = {40'd0, 1'b1, y[22:0]};
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        s  = x[31] ^ y[31];
        r.c = '0;
        r.f = '0;
        r.special = 1'b1;
        if (nx || ny || (zx && zy) || (ix && iy)) begin
            r.c = 32'h7FC0_0000;
            r.f = 5'b10000;
        end else if (ix || zy) begin
            r.c = {s, 31'h7F80_0000};
            r.f = (zy && !ix) ? 5'b01000 : 5'b00000;
        end else if (zx || iy) begin
            r.c = {s, 31'd0};
        end else begin
            r.special = 1'b0;
            e = ex - ey + 127;
            if (mx >= my) num = mx << 24;
            else begin
                num = mx << 25;
                e = e - 1;
            end
            qq  = num / my;
            rr  = num % my;
            sig = qq >> 1;
            g   = qq[0];
            st  = (rr != 0);
            if (g && (st || sig[0])) sig = sig + 1;
            if (sig[24]) begin
                sig = sig >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                r.c = {s, 31'h7F80_0000};
                r.f = 5'b00101;
            end else if (e <= 0) begin
                r.c = {s, 31'd0};
                r.f = 5'b00011;
            end else begin
                r.c = {s, e[7:0], sig[22:0]};
                r.f = {4'b0000, g | st};
            end
        end
        return r;
    endfunction

    // Single compare process: handshake, latency and result against the model every cycle.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
        end else begin
            check("in_ready", in_ready, pend.size() == 0);
            if (pend.size() == 0) begin
                check("out_valid_idle", out_valid, 1'b0);
            end else begin
                check("out_valid_timing", out_valid, (cycle - pend[0].acc + 1) >= pend[0].lat);
                if (out_valid) begin
                    check("model_c", c, pend[0].c);
                    check("model_flags", flags, pend[0].f);
                    if (out_ready) void'(pend.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                mres     = model(a, b);
                item.c   = mres.c;
                item.f   = mres.f;
                item.acc = cycle + 1;
                item.lat = mres.special ? 1 : 27;
                pend.push_back(item);
            end
        end
    end

    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] ec, input logic [4:0] ef, input int elat, input int hold);
        int   n;
        res_t m;
        m = model(ta, tb_v);
        check({name, "_model_c"}, m.c, ec);
        check({name, "_model_flags"}, m.f, ef);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        a = ta;
        b = tb_v;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #2;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        check({name, "_latency"}, n + 1, elat);
        check({name, "_c"}, c, ec);
        check({name, "_flags"}, flags, ef);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                a = 32'h3F80_0000;
                b = 32'h4040_0000;
                in_valid = 1'b1;
                @(posedge clk); #2;
                check({name, "_hold_c"}, c, ec);
                check({name, "_hold_in_ready"}, in_ready, 1'b0);
                check({name, "_hold_out_valid"}, out_valid, 1'b1);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #2;
            check({name, "_release_in_ready"}, in_ready, 1'b1);
            check({name, "_release_out_valid"}, out_valid, 1'b0);
        end else begin
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check("reset_c", c, 32'h0);
        check("reset_flags", flags, 5'h0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);

        run_op("div_6_2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 27, 0);
        run_op("div_1_3",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 5'b00001, 27, 0);
        run_op("div_m7_2",     32'hC0E0_0000, 32'h4000_0000, 32'hC060_0000, 5'b00000, 27, 0);
        run_op("one_by_zero",  32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b01000, 1, 0);
        run_op("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b10000, 1, 0);
        run_op("neg_by_zero",  32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 5'b01000, 1, 0);
        run_op("nan_operand",  32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 5'b10000, 1, 0);
        run_op("inf_by_inf",   32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 5'b10000, 1, 0);
        run_op("inf_by_two",   32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 5'b00000, 1, 0);
        run_op("inf_by_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b00000, 1, 0);
        run_op("neg_by_inf",   32'hC000_0000, 32'h7F80_0000, 32'h8000_0000, 5'b00000, 1, 0);
        run_op("denorm_a",     32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 5'b00000, 1, 0);
        run_op("denorm_b",     32'h3F80_0000, 32'h8000_0001, 32'hFF80_0000, 5'b01000, 1, 0);
        run_op("overflow",     32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 5'b00101, 27, 0);
        run_op("underflow",    32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 5'b00011, 27, 0);
        run_op("backpressure", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 27, 10);

        // Reset ten cycles into a division must drop it without any output.
        a = 32'h40C0_0000;
        b = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #2;
        end
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        repeat (30) begin
            @(posedge clk); #2;
            check("midrst_no_stale", out_valid, 1'b0);
        end
        run_op("after_reset", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 27, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
